// File: rtl/sopc_scope_sys_trigout.sv
// Avalon-MM trigger-out port: static idle level or a timed inverted pulse of
// programmable width, with a sticky done flag and maskable level interrupt.
module sopc_scope_sys_trigout #(
   parameter int unsigned CNT_W       = 16,
   parameter logic        RESET_LEVEL = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq,
   output logic        out_port
);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t            state_q, state_d;
   logic              out_q, out_d;
   logic              idle_q, idle_d;
   logic              pol_q, pol_d;
   logic              mask_q, mask_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  width_q, width_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       readdata_q, readdata_d;

   logic wr, wr_data, wr_width, wr_mask, wr_ctrl;

   always_comb begin
      wr       = chipselect & ~write_n;
      wr_data  = wr && (address == 2'd0);
      wr_width = wr && (address == 2'd1);
      wr_mask  = wr && (address == 2'd2);
      wr_ctrl  = wr && (address == 2'd3);

      state_d = state_q;
      pol_d   = pol_q;
      cnt_d   = cnt_q;
      idle_d  = wr_data  ? writedata[0]          : idle_q;
      width_d = wr_width ? writedata[CNT_W-1:0]  : width_q;
      mask_d  = wr_mask  ? writedata[0]          : mask_q;
      done_d  = (wr_ctrl && writedata[1]) ? 1'b0 : done_q;

      unique case (state_q)
         ST_IDLE: begin
            if (wr_ctrl && writedata[0]) begin
               state_d = ST_ACTIVE;
               pol_d   = idle_q;
               cnt_d   = (width_q == '0) ? CNT_ONE : width_q;
            end
         end
         ST_ACTIVE: begin
            // abort beats completion; completion's done set beats CLR_DONE
            if (wr_ctrl && writedata[2]) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_ONE) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      out_d = (state_d == ST_ACTIVE) ? ~pol_d : idle_d;

      unique case (address)
         2'd0:    readdata_d = {31'd0, out_q};
         2'd1:    readdata_d = 32'(width_q);
         2'd2:    readdata_d = {31'd0, mask_q};
         default: readdata_d = {30'd0, done_q, state_q == ST_ACTIVE};
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         out_q      <= RESET_LEVEL;
         idle_q     <= RESET_LEVEL;
         pol_q      <= RESET_LEVEL;
         mask_q     <= 1'b0;
         done_q     <= 1'b0;
         width_q    <= '0;
         cnt_q      <= '0;
         readdata_q <= '0;
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         idle_q     <= idle_d;
         pol_q      <= pol_d;
         mask_q     <= mask_d;
         done_q     <= done_d;
         width_q    <= width_d;
         cnt_q      <= cnt_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign out_port = out_q;
   assign irq      = done_q & mask_q;

endmodule

// File: tb/tb_sopc_scope_sys_trigout.sv
// Directed bench for sopc_scope_sys_trigout: expectations are queued before each
// stimulus step and popped when the corresponding DUT output is sampled.
module tb_sopc_scope_sys_trigout;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;
   logic        out_port;

   int unsigned total = 0;
   int unsigned bad   = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];

   sopc_scope_sys_trigout #(.CNT_W(16), .RESET_LEVEL(1'b0)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [31:0] e);
      exp_t x;
      x.tag = tag;
      x.exp = e;
      sb.push_back(x);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t x;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $error("FAIL sb_underflow got=%0h exp=<none>", obs);
      end else begin
         x = sb.pop_front();
         assert (obs === x.exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", x.tag, obs, x.exp);
         end
      end
   endtask

   // write lands on the next rising edge; returns 1ns after that edge
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a;
      @(posedge clk);
      #1;
      d = readdata;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] r;
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;

      // reset state
      #12;
      push("rst_out", 0);  check(32'(out_port));
      push("rst_rd",  0);  check(readdata);
      push("rst_irq", 0);  check(32'(irq));
      @(negedge clk); reset_n = 1'b1;

      // T2: DATA follows at the write edge, readback one cycle later
      push("t2_out1", 1);  wr(0, 1);  check(32'(out_port));
      push("t2_rd1",  1);  rd(0, r);  check(r);
      push("t2_out0", 0);  wr(0, 0);  check(32'(out_port));
      push("t2_rd0",  0);  rd(0, r);  check(r);

      // T3: width 5 pulse
      wr(1, 5);
      push("t3_e0", 1);  wr(3, 1);  check(32'(out_port));
      for (int i = 1; i < 5; i++) begin
         push("t3_hi", 1);  tick();  check(32'(out_port));
      end
      push("t3_end", 0);  tick();  check(32'(out_port));
      push("t3_ctrl", 2); rd(3, r); check(r);

      // T4: width 0 gives one cycle; START while busy does not extend
      wr(3, 2);
      wr(1, 0);
      push("t4_w0_hi", 1);  wr(3, 1);  check(32'(out_port));
      push("t4_w0_lo", 0);  tick();    check(32'(out_port));
      wr(1, 3);
      push("t4_s_e0", 1);   wr(3, 1);  check(32'(out_port));
      push("t4_s_e1", 1);   wr(3, 1);  check(32'(out_port));
      push("t4_s_e2", 1);   tick();    check(32'(out_port));
      push("t4_s_e3", 0);   tick();    check(32'(out_port));
      push("t4_busy0", 2);  rd(3, r);  check(r);

      // T5: irq, CLR_DONE, and CLR_DONE colliding with completion
      wr(3, 2);
      push("t5_irq_m", 0);  wr(2, 1);  check(32'(irq));
      wr(1, 2);
      wr(3, 1);
      tick();
      push("t5_irq1", 1);   tick();    check(32'(irq));
      push("t5_clr", 0);    wr(3, 2);  check(32'(irq));
      wr(3, 1);
      tick();
      push("t5_col_irq", 1); wr(3, 2); check(32'(irq));
      push("t5_col_out", 0); check(32'(out_port));
      push("t5_col_ctrl", 2); rd(3, r); check(r);
      wr(2, 0);
      push("t5_mask0", 0);  check(32'(irq));

      // T6: abort mid-pulse, then DATA write mid-pulse sets the end level
      wr(3, 2);
      wr(1, 10);
      wr(3, 1);
      repeat (3) tick();
      push("t6_abort", 0);   wr(3, 4);  check(32'(out_port));
      push("t6_ab_ctrl", 0); rd(3, r);  check(r);
      wr(1, 4);
      push("t6_d_e0", 1);    wr(3, 1);  check(32'(out_port));
      push("t6_d_e1", 1);    wr(0, 1);  check(32'(out_port));
      push("t6_d_e2", 1);    tick();    check(32'(out_port));
      push("t6_d_e3", 1);    tick();    check(32'(out_port));
      push("t6_d_end", 1);   tick();    check(32'(out_port));
      push("t6_d_ctrl", 2);  rd(3, r);  check(r);

      // START+ABORT together: START wins in IDLE, ABORT wins in ACTIVE
      push("sa_idle", 0);    wr(3, 5);  check(32'(out_port));
      push("sa_act", 1);     wr(3, 5);  check(32'(out_port));
      push("sa_ctrl", 2);    rd(3, r);  check(r);
      push("idle_abort", 1); wr(3, 4);  check(32'(out_port));

      // WIDTH keeps only CNT_W bits
      wr(1, 32'hFFFF_FFFF);
      push("width_rd", 32'h0000_FFFF); rd(1, r); check(r);

      // T1: reset mid-pulse
      wr(0, 0);
      wr(2, 1);
      wr(1, 100);
      wr(3, 1);
      repeat (49) tick();
      push("t1_pre", 1);  check(32'(out_port));
      @(negedge clk); #2; reset_n = 1'b0; #1;
      push("t1_out", 0);  check(32'(out_port));
      push("t1_rd",  0);  check(readdata);
      push("t1_irq", 0);  check(32'(irq));
      @(negedge clk); reset_n = 1'b1;
      push("t1_ctrl", 0); rd(3, r); check(r);
      push("t1_mask", 0); rd(2, r); check(r);
      push("t1_wid",  0); rd(1, r); check(r);
      repeat (3) tick();
      push("t1_irq_after", 0); check(32'(irq));

      total++;
      assert (sb.size() == 0) else begin
         bad++;
         $error("FAIL sb_leftover got=%0d exp=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
